// File: rtl/branch_ctrl_if.sv
// Signal bundle between the ID-stage branch comparator datapath and its
// sequencing controller.
interface branch_ctrl_if #(
    parameter int CNT_W = 16
);
    // ID-stage instruction fields
    logic             id_valid;
    logic [5:0]       id_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ext_stall;
    // Producers further down the pipe
    logic             ex_regwrite;
    logic [4:0]       ex_wreg;
    logic             mem_regwrite;
    logic             mem_memtoreg;
    logic [4:0]       mem_wreg;
    logic             wb_regwrite;
    logic [4:0]       wb_wreg;
    // Comparator result
    logic             cmp_y;
    // Controller decisions and statistics
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall_fd;
    logic             pcsrc;
    logic             link_we;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;

    // Pipeline side: supplies instruction and producer state
    modport master (
        output id_valid, id_op, id_rs, id_rt, ext_stall,
        output ex_regwrite, ex_wreg,
        output mem_regwrite, mem_memtoreg, mem_wreg,
        output wb_regwrite, wb_wreg, cmp_y,
        input  fwd_a, fwd_b, stall_fd, pcsrc, link_we,
        input  branch_cnt, taken_cnt, stall_cnt, err
    );

    // Controller side
    modport slave (
        input  id_valid, id_op, id_rs, id_rt, ext_stall,
        input  ex_regwrite, ex_wreg,
        input  mem_regwrite, mem_memtoreg, mem_wreg,
        input  wb_regwrite, wb_wreg, cmp_y,
        output fwd_a, fwd_b, stall_fd, pcsrc, link_we,
        output branch_cnt, taken_cnt, stall_cnt, err
    );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencing controller: decodes branches, detects operand
// hazards against EX/MEM/WB, steers comparator forwarding, stalls F/D until
// operands are ready, qualifies pcsrc/link_we, and keeps saturating
// statistics plus a hazard-stall watchdog.
module branch_ctrl #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic        clk,
    input  logic        resetn,
    branch_ctrl_if.slave bus
);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Run counter only needs to reach MAX_STALL+1, where it parks.
    localparam int               RUN_W   = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);

    typedef enum logic {IDLE, HAZ} state_t;

    state_t           state, next_state;
    logic             is_br, uses_rt, is_link;
    logic             hazard, br_active, resolve;
    logic [RUN_W-1:0] run;
    logic [CNT_W-1:0] branch_cnt, taken_cnt, stall_cnt;
    logic             err;

    // A source is blocked while EX will write it, or MEM holds a load to it
    // (load data is not available until WB). r0 never blocks.
    function automatic logic src_busy(
        input logic [4:0] src,
        input logic       ex_rw,  input logic [4:0] ex_w,
        input logic       mem_rw, input logic mem_ld, input logic [4:0] mem_w
    );
        return (src != 5'd0) &&
               ((ex_rw && ex_w == src) || (mem_rw && mem_ld && mem_w == src));
    endfunction

    // Nearest producer wins: MEM ALU result first, then WB, else regfile.
    function automatic logic [1:0] src_fwd(
        input logic [4:0] src,
        input logic       mem_rw, input logic mem_ld, input logic [4:0] mem_w,
        input logic       wb_rw,  input logic [4:0] wb_w
    );
        if (src == 5'd0)                           return FWD_RF;
        else if (mem_rw && !mem_ld && mem_w == src) return FWD_MEM;
        else if (wb_rw && wb_w == src)              return FWD_WB;
        else                                        return FWD_RF;
    endfunction

    // Branch class decode from opcode and (for REGIMM) the rt field
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        is_br   = 1'b0;
        uses_rt = 1'b0;
        is_link = 1'b0;
        case (bus.id_op)
            OP_BEQ, OP_BNE: begin
                is_br   = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: is_br = 1'b1;
            OP_REGIMM: begin
                // BLTZ/BGEZ/BLTZAL/BGEZAL are rt = {0,1,16,17}
                is_br   = (bus.id_rt[3:1] == 3'b000);
                is_link = (bus.id_rt[3:1] == 3'b000) && bus.id_rt[4];
            end
            default: ;
        endcase
    end

    // Hazard and resolve qualification; everything is forced idle in reset
    always_comb begin
        hazard = is_br &&
                 (src_busy(bus.id_rs, bus.ex_regwrite, bus.ex_wreg,
                           bus.mem_regwrite, bus.mem_memtoreg, bus.mem_wreg) ||
                  (uses_rt &&
                   src_busy(bus.id_rt, bus.ex_regwrite, bus.ex_wreg,
                            bus.mem_regwrite, bus.mem_memtoreg, bus.mem_wreg)));
        br_active = resetn && bus.id_valid && is_br;
        resolve   = br_active && !hazard && !bus.ext_stall;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: asynchronous reset lives in the sensitivity list; sequential state uses non-blocking assignments only.
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic: HAZ tracks an ongoing hazard stall for the watchdog
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.id_valid && is_br && hazard) next_state = HAZ;
            HAZ:  if (!hazard || !bus.id_valid)        next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: decisions are purely combinational on the current inputs
    always_comb begin
        bus.fwd_a    = FWD_RF;
        bus.fwd_b    = FWD_RF;
        bus.stall_fd = br_active && hazard;
        bus.pcsrc    = resolve && bus.cmp_y;
        bus.link_we  = resolve && is_link;
        if (resetn && bus.id_valid) begin
            bus.fwd_a = src_fwd(bus.id_rs, bus.mem_regwrite, bus.mem_memtoreg,
                                bus.mem_wreg, bus.wb_regwrite, bus.wb_wreg);
            if (uses_rt)
                bus.fwd_b = src_fwd(bus.id_rt, bus.mem_regwrite, bus.mem_memtoreg,
                                    bus.mem_wreg, bus.wb_regwrite, bus.wb_wreg);
        end
    end

    // Watchdog: count consecutive HAZ cycles, flag once the run exceeds MAX_STALL
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run <= '0;
            err <= 1'b0;
        end else if (state == HAZ) begin
            if (run >= RUN_LIM)    err <= 1'b1;
            if (next_state != HAZ) run <= '0;
            else if (run != RUN_MAX) run <= run + 1'b1;
        end else begin
            run <= '0;
        end
    end

    // Saturating statistics; frozen while ext_stall holds ID
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (resolve && branch_cnt != '1)                 branch_cnt <= branch_cnt + 1'b1;
            if (resolve && bus.cmp_y && taken_cnt != '1)     taken_cnt  <= taken_cnt + 1'b1;
            if (br_active && hazard && !bus.ext_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.branch_cnt = branch_cnt;
    assign bus.taken_cnt  = taken_cnt;
    assign bus.stall_cnt  = stall_cnt;
    assign bus.err        = err;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl with a behavioural reference model.
module tb_branch_ctrl;

    localparam int CW  = 4;   // narrow counters so saturation is reachable quickly
    localparam int MAX = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_ctrl_if #(.CNT_W(CW)) bus ();

    branch_ctrl #(.CNT_W(CW), .MAX_STALL(MAX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_is_br(input logic [5:0] op, input logic [4:0] rt);
        return (op inside {6'd4, 6'd5, 6'd6, 6'd7}) ||
               (op == 6'd1 && (rt inside {5'd0, 5'd1, 5'd16, 5'd17}));
    endfunction

    function automatic bit m_uses_rt(input logic [5:0] op);
        return op inside {6'd4, 6'd5};
    endfunction

    function automatic bit m_is_link(input logic [5:0] op, input logic [4:0] rt);
        return op == 6'd1 && (rt inside {5'd16, 5'd17});
    endfunction

    // Value for register r is not yet obtainable by the comparator
    function automatic bit m_busy(input logic [4:0] r);
        if (r == 0) return 0;
        if (bus.ex_regwrite && bus.ex_wreg == r) return 1;
        if (bus.mem_regwrite && bus.mem_memtoreg && bus.mem_wreg == r) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (r == 0) return 2'd0;
        if (bus.mem_regwrite && !bus.mem_memtoreg && bus.mem_wreg == r) return 2'd1;
        if (bus.wb_regwrite && bus.wb_wreg == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    int m_branch, m_taken, m_stall, m_run;
    bit m_in_haz, m_err, commit;
    int n_branch, n_taken, n_stall, n_run;
    bit n_in_haz, n_err;

    initial begin
        m_branch = 0; m_taken = 0; m_stall = 0; m_run = 0;
        m_in_haz = 0; m_err = 0; commit = 0;
    end

    // Compare process: checks every cycle at the falling edge, then prepares
    // the model's next registered state for the coming rising edge.
    always @(negedge clk) begin
        bit br, haz, res;
        logic [1:0] ea, eb;
        if (!resetn) begin
            m_branch = 0; m_taken = 0; m_stall = 0; m_run = 0;
            m_in_haz = 0; m_err = 0; commit = 0;
            br = 0; haz = 0; res = 0; ea = 0; eb = 0;
        end else begin
            br  = bus.id_valid && m_is_br(bus.id_op, bus.id_rt);
            haz = br && (m_busy(bus.id_rs) || (m_uses_rt(bus.id_op) && m_busy(bus.id_rt)));
            res = br && !haz && !bus.ext_stall;
            ea  = bus.id_valid ? m_fwd(bus.id_rs) : 2'd0;
            eb  = (bus.id_valid && m_uses_rt(bus.id_op)) ? m_fwd(bus.id_rt) : 2'd0;
        end
        check("m_fwd_a",      bus.fwd_a,      ea);
        check("m_fwd_b",      bus.fwd_b,      eb);
        check("m_stall_fd",   bus.stall_fd,   haz);
        check("m_pcsrc",      bus.pcsrc,      res && bus.cmp_y);
        check("m_link_we",    bus.link_we,    res && m_is_link(bus.id_op, bus.id_rt));
        check("m_branch_cnt", bus.branch_cnt, m_branch);
        check("m_taken_cnt",  bus.taken_cnt,  m_taken);
        check("m_stall_cnt",  bus.stall_cnt,  m_stall);
        check("m_err",        bus.err,        m_err);
        if (resetn) begin
            n_branch = res ? sat_inc(m_branch) : m_branch;
            n_taken  = (res && bus.cmp_y) ? sat_inc(m_taken) : m_taken;
            n_stall  = (haz && !bus.ext_stall) ? sat_inc(m_stall) : m_stall;
            // A stall run continues while the same hazard keeps the branch stuck
            n_in_haz = haz;
            n_run    = (m_in_haz && haz) ? m_run + 1 : 0;
            n_err    = m_err || (m_in_haz && (m_run + 1 > MAX));
            commit   = 1;
        end
    end

    always @(posedge clk) begin
        if (commit && resetn) begin
            m_branch = n_branch; m_taken = n_taken; m_stall = n_stall;
            m_in_haz = n_in_haz; m_run = n_run; m_err = n_err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                            input logic [4:0] rt, input logic cy);
        bus.id_valid = v;
        bus.id_op    = op;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.cmp_y    = cy;
    endtask

    task automatic clear_prod();
        bus.ext_stall    = 1'b0;
        bus.ex_regwrite  = 1'b0;
        bus.ex_wreg      = 5'd0;
        bus.mem_regwrite = 1'b0;
        bus.mem_memtoreg = 1'b0;
        bus.mem_wreg     = 5'd0;
        bus.wb_regwrite  = 1'b0;
        bus.wb_wreg      = 5'd0;
    endtask

    initial begin
        // Reset with a hazarding branch present: outputs must stay quiet
        resetn = 1'b0;
        clear_prod();
        drive_id(1'b1, 6'd4, 5'd5, 5'd6, 1'b1);
        bus.ex_regwrite = 1'b1;
        bus.ex_wreg     = 5'd5;
        repeat (2) @(negedge clk);
        check("rst_stall_fd",   bus.stall_fd,   0);
        check("rst_pcsrc",      bus.pcsrc,      0);
        check("rst_branch_cnt", bus.branch_cnt, 0);
        check("rst_err",        bus.err,        0);
        step();
        resetn = 1'b1;
        clear_prod();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);

        // T1: BEQ r5,r6, no producers, taken
        step();
        drive_id(1'b1, 6'd4, 5'd5, 5'd6, 1'b1);
        @(negedge clk);
        check("t1_stall_fd", bus.stall_fd, 0);
        check("t1_fwd_a",    bus.fwd_a,    0);
        check("t1_fwd_b",    bus.fwd_b,    0);
        check("t1_pcsrc",    bus.pcsrc,    1);
        step();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("t1_branch_cnt", bus.branch_cnt, 1);
        check("t1_taken_cnt",  bus.taken_cnt,  1);

        // T2: BNE with EX writing r5, then producer in MEM as ALU op
        step();
        drive_id(1'b1, 6'd5, 5'd5, 5'd7, 1'b0);
        bus.ex_regwrite = 1'b1;
        bus.ex_wreg     = 5'd5;
        @(negedge clk);
        check("t2_stall_fd", bus.stall_fd, 1);
        step();
        bus.ex_regwrite  = 1'b0;
        bus.mem_regwrite = 1'b1;
        bus.mem_wreg     = 5'd5;
        bus.cmp_y        = 1'b1;
        @(negedge clk);
        check("t2_fwd_a",     bus.fwd_a,     1);
        check("t2_stall_fd",  bus.stall_fd,  0);
        check("t2_pcsrc",     bus.pcsrc,     1);
        check("t2_stall_cnt", bus.stall_cnt, 1);
        step();
        clear_prod();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("t2_branch_cnt", bus.branch_cnt, 2);

        // T3: BGTZ r8 behind a load: EX then MEM-load stall, then WB forward
        step();
        drive_id(1'b1, 6'd7, 5'd8, 5'd0, 1'b0);
        bus.ex_regwrite = 1'b1;
        bus.ex_wreg     = 5'd8;
        @(negedge clk);
        check("t3_stall_ex", bus.stall_fd, 1);
        step();
        bus.ex_regwrite  = 1'b0;
        bus.mem_regwrite = 1'b1;
        bus.mem_memtoreg = 1'b1;
        bus.mem_wreg     = 5'd8;
        @(negedge clk);
        check("t3_stall_mem", bus.stall_fd, 1);
        check("t3_fwd_a_ld",  bus.fwd_a,    0);
        step();
        bus.mem_regwrite = 1'b0;
        bus.mem_memtoreg = 1'b0;
        bus.wb_regwrite  = 1'b1;
        bus.wb_wreg      = 5'd8;
        @(negedge clk);
        check("t3_stall_fd",  bus.stall_fd,  0);
        check("t3_fwd_a",     bus.fwd_a,     2);
        check("t3_pcsrc",     bus.pcsrc,     0);
        check("t3_stall_cnt", bus.stall_cnt, 3);
        check("t3_err",       bus.err,       0);
        step();
        clear_prod();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("t3_branch_cnt", bus.branch_cnt, 3);
        check("t3_taken_cnt",  bus.taken_cnt,  2);

        // T4: BLTZAL not taken still links; REGIMM rt=3 is not a branch
        step();
        drive_id(1'b1, 6'd1, 5'd9, 5'd16, 1'b0);
        @(negedge clk);
        check("t4_pcsrc",   bus.pcsrc,   0);
        check("t4_link_we", bus.link_we, 1);
        step();
        drive_id(1'b1, 6'd1, 5'd9, 5'd3, 1'b1);
        @(negedge clk);
        check("t4_nb_link",   bus.link_we,    0);
        check("t4_nb_pcsrc",  bus.pcsrc,      0);
        check("t4_branch",    bus.branch_cnt, 4);
        step();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("t4_nb_branch", bus.branch_cnt, 4);

        // T5: BEQ r0,r0 with EX writing r0, held by ext_stall for 3 cycles
        step();
        drive_id(1'b1, 6'd4, 5'd0, 5'd0, 1'b1);
        bus.ex_regwrite = 1'b1;
        bus.ex_wreg     = 5'd0;
        bus.ext_stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            @(negedge clk);
            check("t5_es_stall", bus.stall_fd, 0);
            check("t5_es_pcsrc", bus.pcsrc,    0);
        end
        step();
        bus.ext_stall = 1'b0;
        @(negedge clk);
        check("t5_pcsrc", bus.pcsrc, 1);
        step();
        clear_prod();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("t5_branch_cnt", bus.branch_cnt, 5);
        check("t5_taken_cnt",  bus.taken_cnt,  3);
        // rt hazard under ext_stall: stall shown but not counted
        step();
        drive_id(1'b1, 6'd4, 5'd3, 5'd4, 1'b0);
        bus.ex_regwrite = 1'b1;
        bus.ex_wreg     = 5'd4;
        bus.ext_stall   = 1'b1;
        @(negedge clk);
        check("t5_rt_stall", bus.stall_fd, 1);
        // BLEZ ignores its rt field for hazards
        step();
        bus.ext_stall = 1'b0;
        drive_id(1'b1, 6'd6, 5'd2, 5'd4, 1'b1);
        @(negedge clk);
        check("t5_blez_stall", bus.stall_fd,  0);
        check("t5_blez_pcsrc", bus.pcsrc,     1);
        check("t5_stall_cnt",  bus.stall_cnt, 3);
        step();
        clear_prod();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);

        // T6: hazard held long enough to trip the watchdog, then reset mid-HAZ
        step();
        drive_id(1'b1, 6'd5, 5'd12, 5'd0, 1'b0);
        bus.ex_regwrite = 1'b1;
        bus.ex_wreg     = 5'd12;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            @(negedge clk);
            check("t6_stall", bus.stall_fd, 1);
            if (k == 6) check("t6_err_pre", bus.err, 0);
            if (k == 7) begin
                check("t6_err",       bus.err,       1);
                check("t6_stall_cnt", bus.stall_cnt, 9);
            end
        end
        step();
        resetn = 1'b0;
        @(negedge clk);
        check("t6_rst_stall",  bus.stall_fd,   0);
        check("t6_rst_err",    bus.err,        0);
        check("t6_rst_branch", bus.branch_cnt, 0);
        check("t6_rst_scnt",   bus.stall_cnt,  0);
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("t6_post_stall", bus.stall_fd, 1);
        step();
        clear_prod();
        drive_id(1'b1, 6'd4, 5'd5, 5'd6, 1'b0);
        @(negedge clk);
        check("t6_post_scnt",  bus.stall_cnt, 1);
        check("t6_post_pcsrc", bus.pcsrc,     0);
        step();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("t6_post_branch", bus.branch_cnt, 1);
        check("t6_post_taken",  bus.taken_cnt,  0);

        // T7: drive counters past all-ones; they must stick
        for (int i = 0; i < SAT + 2; i++) begin
            step();
            drive_id(1'b1, 6'd4, 5'd5, 5'd6, 1'b1);
        end
        step();
        drive_id(1'b0, 6'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        check("t7_branch_sat", bus.branch_cnt, SAT);
        check("t7_taken_sat",  bus.taken_cnt,  SAT);

        repeat (2) step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
